pipeline_debug_dumper: RTL and testbench
========================================

# pipeline_debug_dumper

Debug reader for the five-stage pipeline's observation buses. It owns the pipeline `enable` line to provide continuous-run and single-step modes. On request, it freezes the pipeline, captures one coherent snapshot of PC, fetched instruction, all four inter-stage latches and the full register file, and streams it byte-serially over a valid/ready handshake to the UART transmitter. It sits between the top-level pipeline and the debug UART.

## Interface
- Parameters:
  - `HEADER`, 8'hA5: first byte of every frame.
  - `FRAME_BYTES`, 181: bytes per frame, fixed by the port widths; not user-tunable.
- Ports:
  - `clk`  in  1  system clock; all state updates on the rising edge.
  - `rst`  in  1  reset; asynchronous, active-high.
  - `mode_cont`  in  1  1 = continuous run, 0 = single-step.
  - `step_req`  in  1  one-cycle pulse requesting a single step (step mode only).
  - `dump_req`  in  1  one-cycle pulse requesting a snapshot dump.
  - `pc`  in  8  current PC.
  - `instruccion`  in  32  fetched instruction.
  - `if_id`  in  40  IF/ID latch view.
  - `id_ex`  in  144  ID/EX latch view.
  - `ex_m`  in  80  EX/MEM latch view.
  - `m_wb`  in  80  MEM/WB latch view.
  - `registros`  in  1024  register file, r31 in bits [1023:992].
  - `pipe_enable`  out  1  drives the pipeline `enable`.
  - `tx_data`  out  8  byte to the transmitter.
  - `tx_valid`  out  1  `tx_data` is valid.
  - `tx_ready`  in  1  transmitter accepts the byte this cycle.
  - `busy`  out  1  high in every state except IDLE.
  - `cycle_count`  out  32  number of enabled pipeline cycles.

## Operation
- States:
  - IDLE, STEP, CAPTURE and SEND.
- `pipe_enable`:
  - Equals (IDLE && `mode_cont`) || STEP.
  - It is combinational from the state register and `mode_cont`.
- IDLE transitions:
  - `step_req` && !`mode_cont` goes to STEP. If `step_req` and `dump_req` arrive together in step mode, step wins; its automatic dump covers the request.
  - Otherwise `dump_req` goes to CAPTURE.
  - Otherwise the block stays in IDLE.
- STEP lasts exactly one cycle, then goes to CAPTURE. The step's dump is automatic.
- CAPTURE lasts one cycle with `pipe_enable`=0. At its closing edge, a 1448-bit shift register loads the following, MSB first, and the state goes to SEND:
  - `HEADER`, `cycle_count`, `pc`, `instruccion`, `if_id`, `id_ex`, `ex_m`, `m_wb`, `registros`.
  - This is 1+4+1+4+5+18+10+10+128 = 181 bytes.
- SEND:
  - `tx_valid`=1 and `tx_data`= the top byte of the shift register.
  - On `tx_valid && tx_ready`, shift left 8 bits and increment the 8-bit byte index.
  - When the byte with index 180 is accepted, go to IDLE.
- Handshake rules:
  - `tx_data` is held stable while `tx_valid && !tx_ready`.
  - `tx_valid` never drops before acceptance.
  - `tx_valid`=0 outside SEND.
- Requests arriving in any state other than IDLE are ignored, not queued. `step_req` in continuous mode is ignored.
- A `mode_cont` change while busy takes effect only on return to IDLE.
- `cycle_count` increments at every edge where `pipe_enable`=1. It wraps from 32'hFFFFFFFF to 0.

## Timing
- Reset values:
  - state IDLE, `pipe_enable` = `mode_cont` (combinational), `tx_valid` 0, `tx_data` 8'h00.
  - `busy` 0, `cycle_count` 0, shift register 0, byte index 0.
- `rst` asserted mid-dump aborts immediately: `tx_valid` falls asynchronously and no partial frame resumes.
- Dump latency: `dump_req` sampled at edge k (IDLE) gives CAPTURE during cycle k..k+1. The first `tx_valid` with `tx_data`=8'hA5 appears after edge k+1.
- In continuous mode the pipeline still advances at edge k. The snapshot reflects the state after that advance, and `cycle_count` includes it.
- Step: `step_req` at edge k gives `pipe_enable`=1 for exactly cycle k..k+1, then CAPTURE, then the first byte after edge k+2.
- Frame duration with `tx_ready` held high is 181 cycles in SEND. Minimum IDLE-to-IDLE time is 182 cycles (dump) or 183 cycles (step).
- In continuous mode `pipe_enable` is low from CAPTURE entry until return to IDLE.

## Test plan
- Reset then step mode:
  - Stimulus: `step_req` pulse, `tx_ready`=1.
  - Required: `pipe_enable` high for exactly 1 cycle, then 181 bytes; byte0=8'hA5, bytes1–4=00 00 00 01, byte5=`pc`, bytes 53–180 = `registros` MSB-first. Back to IDLE with `busy`=0.
- Continuous mode with a driven counter model:
  - Stimulus: `dump_req` after 10 enabled cycles.
  - Required: `pipe_enable` drops the cycle after the request; frame `cycle_count`=11; `pipe_enable` returns to 1 after the last byte.
- Backpressure:
  - Stimulus: toggle `tx_ready` pseudo-randomly, holding it low for up to 5 cycles.
  - Required: `tx_data` stable while stalled, no byte lost or duplicated, exactly 181 handshakes.
- Ignored requests:
  - Stimulus: `dump_req`/`step_req` pulses during SEND; `step_req` with `mode_cont`=1.
  - Required: no extra frame, no extra `pipe_enable` cycle.
- Reset mid-frame:
  - Stimulus: assert `rst` at byte 50 between clock edges.
  - Required: `tx_valid` falls immediately, `cycle_count`=0, next `dump_req` yields a fresh frame starting with 8'hA5.
- Wrap:
  - Stimulus: force `cycle_count` to 32'hFFFFFFFF, then one step.
  - Required: frame reports 32'h00000000.

Source files
------------

// File: rtl/pipeline_debug_dumper.sv
// Debug reader for the five-stage pipeline's observation buses.
// It owns the pipeline enable line (continuous-run / single-step). On request it
// freezes the pipeline and takes one coherent snapshot of the pipeline state.
// The snapshot is streamed MSB-first, one byte at a time, over a valid/ready
// handshake to the debug UART transmitter.
module pipeline_debug_dumper #(
  parameter logic [7:0] HEADER      = 8'hA5,
  parameter int         FRAME_BYTES = 181
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mode_cont,
  input  logic          step_req,
  input  logic          dump_req,
  input  logic [7:0]    pc,
  input  logic [31:0]   instruccion,
  input  logic [39:0]   if_id,
  input  logic [143:0]  id_ex,
  input  logic [79:0]   ex_m,
  input  logic [79:0]   m_wb,
  input  logic [1023:0] registros,
  output logic          pipe_enable,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic          busy,
  output logic [31:0]   cycle_count
);

  localparam int FRAME_BITS = FRAME_BYTES * 8;

  typedef enum logic [1:0] {
    IDLE,
    STEP,
    CAPTURE,
    SEND
  } state_t;

  state_t                r_state;
  logic [FRAME_BITS-1:0] r_shift;
  logic [7:0]            r_byte_idx;
  logic                  r_tx_valid;
  logic [31:0]           r_cycle_count;

  logic                  w_pipe_enable;
  logic                  w_accept;
  logic                  w_last_byte;
  logic [FRAME_BITS-1:0] w_snapshot;

  // The pipeline only advances while idle in continuous mode, or for the one STEP cycle.
  assign w_pipe_enable = ((r_state == IDLE) && mode_cont) || (r_state == STEP);

  assign w_accept    = r_tx_valid && tx_ready;
  assign w_last_byte = (r_byte_idx == 8'(FRAME_BYTES - 1));

  // The frame layout: header first, then the counter, then the pipeline state from front to back.
  assign w_snapshot = {HEADER, r_cycle_count, pc, instruccion,
                       if_id, id_ex, ex_m, m_wb, registros};

  assign pipe_enable = w_pipe_enable;
  assign tx_valid    = r_tx_valid;
  assign tx_data     = r_shift[FRAME_BITS-1 -: 8];
  assign busy        = (r_state != IDLE);
  assign cycle_count = r_cycle_count;

  // Control FSM: request arbitration, snapshot load and byte streaming with backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_byte_idx <= 8'd0;
      r_tx_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (step_req && !mode_cont) begin
            r_state <= STEP;
          end else if (dump_req) begin
            r_state <= CAPTURE;
          end
        end
        STEP: begin
          r_state <= CAPTURE;
        end
        CAPTURE: begin
          r_shift    <= w_snapshot;
          r_byte_idx <= 8'd0;
          r_tx_valid <= 1'b1;
          r_state    <= SEND;
        end
        SEND: begin
          if (w_accept) begin
            r_shift <= r_shift << 8;
            if (w_last_byte) begin
              r_byte_idx <= 8'd0;
              r_tx_valid <= 1'b0;
              r_state    <= IDLE;
            end else begin
              r_byte_idx <= r_byte_idx + 8'd1;
            end
          end
        end
        default: begin
          r_state    <= IDLE;
          r_tx_valid <= 1'b0;
        end
      endcase
    end
  end

  // Count every edge at which the pipeline was enabled; wraps naturally at 32 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cycle_count <= 32'd0;
    end else if (w_pipe_enable) begin
      r_cycle_count <= r_cycle_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_debug_dumper.sv
// Self-checking bench for pipeline_debug_dumper. A behavioural model tracks
// what phase the dumper must be in and the bytes it still owes as a queue.
// A per-cycle compare process checks the outputs against it. Directed scenarios
// add literal expectations on the received frames.
module tb_pipeline_debug_dumper;

  localparam logic [7:0] HDR = 8'hA5;
  localparam int PH_IDLE = 0;
  localparam int PH_STEP = 1;
  localparam int PH_CAP  = 2;
  localparam int PH_SEND = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          mode_cont;
  logic          step_req;
  logic          dump_req;
  logic [7:0]    pc;
  logic [31:0]   instruccion;
  logic [39:0]   if_id;
  logic [143:0]  id_ex;
  logic [79:0]   ex_m;
  logic [79:0]   m_wb;
  logic [1023:0] registros;
  logic          pipe_enable;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          busy;
  logic [31:0]   cycle_count;

  int checks   = 0;
  int failures = 0;
  bit checkEn  = 1'b0;
  int bpMode   = 0;
  int stallLeft = 0;

  logic [31:0] pipeCnt;
  logic [7:0]  rxBytes[$];

  int          mdlPhase = PH_IDLE;
  logic [31:0] mdlCount = 32'd0;
  logic [7:0]  mdlQ[$];
  logic        mdlEn;

  logic [7:0]  prevData = 8'h00;
  bit          prevStall = 1'b0;

  pipeline_debug_dumper dut (
    .clk         (clk),
    .rst         (rst),
    .mode_cont   (mode_cont),
    .step_req    (step_req),
    .dump_req    (dump_req),
    .pc          (pc),
    .instruccion (instruccion),
    .if_id       (if_id),
    .id_ex       (id_ex),
    .ex_m        (ex_m),
    .m_wb        (m_wb),
    .registros   (registros),
    .pipe_enable (pipe_enable),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .cycle_count (cycle_count)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // A stand-in pipeline whose observable state advances only while enabled.
  always @(posedge clk or posedge rst) begin
    if (rst) pipeCnt <= 32'd0;
    else if (pipe_enable) pipeCnt <= pipeCnt + 32'd1;
  end

  assign pc          = pipeCnt[7:0];
  assign instruccion = pipeCnt ^ 32'hDEADBEEF;
  assign if_id       = {8'h11, pipeCnt};
  assign id_ex       = {pipeCnt, 112'h0123_4567_89AB_CDEF_FEDC_BA98_7654};
  assign ex_m        = {16'hE0E0, pipeCnt, ~pipeCnt};
  assign m_wb        = {pipeCnt, 48'h0A0B_0C0D_0E0F};

  // Register file pattern, fixed for the whole run so register bytes are easy to predict.
  initial begin
    for (int i = 0; i < 32; i++) registros[i*32 +: 32] = {8'(i), 8'hC3, 8'(i * 7), 8'h3C};
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pushField(input logic [1023:0] v, input int nBytes);
    for (int b = nBytes - 1; b >= 0; b--) mdlQ.push_back(v[b*8 +: 8]);
  endtask

  function automatic logic [7:0] rxAt(input int idx);
    if (idx < rxBytes.size()) return rxBytes[idx];
    return 8'hxx;
  endfunction

  // Behavioural model: one step per clock using the pre-edge inputs.
  // The owed frame is held as a byte queue built field by field.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mdlPhase = PH_IDLE;
      mdlCount = 32'd0;
      mdlQ.delete();
    end else begin
      mdlEn = ((mdlPhase == PH_IDLE) && mode_cont) || (mdlPhase == PH_STEP);
      case (mdlPhase)
        PH_IDLE: begin
          if (step_req && !mode_cont) mdlPhase = PH_STEP;
          else if (dump_req) mdlPhase = PH_CAP;
        end
        PH_STEP: mdlPhase = PH_CAP;
        PH_CAP: begin
          mdlQ.delete();
          pushField(HDR, 1);
          pushField(mdlCount, 4);
          pushField(pc, 1);
          pushField(instruccion, 4);
          pushField(if_id, 5);
          pushField(id_ex, 18);
          pushField(ex_m, 10);
          pushField(m_wb, 10);
          pushField(registros, 128);
          mdlPhase = PH_SEND;
        end
        default: begin
          if (tx_ready) begin
            void'(mdlQ.pop_front());
            if (mdlQ.size() == 0) mdlPhase = PH_IDLE;
          end
        end
      endcase
      if (mdlEn) mdlCount = mdlCount + 32'd1;
    end
  end

  // Per-cycle comparison of every output against the model, just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (checkEn) begin
      checkOutput("busy", busy, 32'(mdlPhase != PH_IDLE));
      checkOutput("pipe_enable", pipe_enable,
                  32'(((mdlPhase == PH_IDLE) && mode_cont) || (mdlPhase == PH_STEP)));
      checkOutput("tx_valid", tx_valid, 32'(mdlPhase == PH_SEND));
      checkOutput("cycle_count", cycle_count, mdlCount);
      if (mdlPhase == PH_SEND && mdlQ.size() > 0) checkOutput("tx_data", tx_data, mdlQ[0]);
    end
  end

  // Transmitter stand-in: always ready, or pseudo-random stalls of up to five cycles.
  always @(negedge clk) begin
    if (bpMode == 0) begin
      tx_ready = 1'b1;
    end else if (stallLeft > 0) begin
      tx_ready  = 1'b0;
      stallLeft = stallLeft - 1;
    end else if ($urandom_range(0, 2) == 0) begin
      tx_ready  = 1'b0;
      stallLeft = int'($urandom_range(0, 4));
    end else begin
      tx_ready = 1'b1;
    end
  end

  // Handshake monitor: collects accepted bytes and checks data/valid hold during stalls.
  always @(negedge clk) begin
    #1;
    if (rst) begin
      prevStall = 1'b0;
    end else begin
      if (prevStall) begin
        checkOutput("valid_hold", tx_valid, 32'd1);
        checkOutput("data_hold", tx_data, prevData);
      end
      if (tx_valid && tx_ready) rxBytes.push_back(tx_data);
      prevStall = tx_valid && !tx_ready;
      prevData  = tx_data;
    end
  end

  task automatic applyStimulus(input logic s, input logic d);
    @(negedge clk);
    step_req = s;
    dump_req = d;
    @(negedge clk);
    step_req = 1'b0;
    dump_req = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    for (int i = 0; i < 3000; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    checkOutput(name, busy, 32'd0);
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios.
  initial begin
    int badRegs;
    int waited;
    rst = 1'b1;
    mode_cont = 1'b0;
    step_req = 1'b0;
    dump_req = 1'b0;
    tx_ready = 1'b1;
    checkEn = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state.
    checkOutput("rst_cycle_count", cycle_count, 32'd0);
    checkOutput("rst_busy", busy, 32'd0);
    checkOutput("rst_tx_valid", tx_valid, 32'd0);
    checkOutput("rst_tx_data", tx_data, 32'h00);
    checkOutput("rst_pipe_enable", pipe_enable, 32'd0);

    // Single step straight out of reset.
    rxBytes.delete();
    applyStimulus(1'b1, 1'b0);
    waitIdle("t1_done");
    checkOutput("t1_nbytes", rxBytes.size(), 32'd181);
    checkOutput("t1_hdr", rxAt(0), 32'hA5);
    checkOutput("t1_cnt_b1", rxAt(1), 32'h00);
    checkOutput("t1_cnt_b2", rxAt(2), 32'h00);
    checkOutput("t1_cnt_b3", rxAt(3), 32'h00);
    checkOutput("t1_cnt_b4", rxAt(4), 32'h01);
    checkOutput("t1_pc", rxAt(5), 32'h01);
    checkOutput("t1_instr_b0", rxAt(6), 32'hDE);
    checkOutput("t1_instr_b3", rxAt(9), 32'hEE);
    checkOutput("t1_ifid_b0", rxAt(10), 32'h11);
    badRegs = 0;
    for (int k = 0; k < 128; k++) begin
      if (rxAt(53 + k) !== registros[1023 - 8*k -: 8]) badRegs++;
    end
    checkOutput("t1_regs_bad_bytes", badRegs, 32'd0);
    checkOutput("t1_r31_top", rxAt(53), 32'h1F);
    checkOutput("t1_r0_low", rxAt(180), 32'h3C);
    checkOutput("t1_cycle_count", cycle_count, 32'd1);
    checkOutput("t1_busy", busy, 32'd0);

    // Continuous mode, dump after ten enabled cycles.
    mode_cont = 1'b1;
    applyReset();
    waited = 0;
    while (cycle_count != 32'd10 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("t2_reach10", cycle_count, 32'd10);
    rxBytes.delete();
    dump_req = 1'b1;
    @(negedge clk);
    dump_req = 1'b0;
    checkOutput("t2_pe_drop", pipe_enable, 32'd0);
    checkOutput("t2_count11", cycle_count, 32'd11);
    waitIdle("t2_done");
    checkOutput("t2_nbytes", rxBytes.size(), 32'd181);
    checkOutput("t2_hdr", rxAt(0), 32'hA5);
    checkOutput("t2_cnt_b3", rxAt(3), 32'h00);
    checkOutput("t2_cnt_b4", rxAt(4), 32'h0B);
    checkOutput("t2_pc", rxAt(5), 32'h0B);
    checkOutput("t2_pe_back", pipe_enable, 32'd1);

    // Backpressure in step mode.
    @(negedge clk);
    mode_cont = 1'b0;
    bpMode = 1;
    rxBytes.delete();
    applyStimulus(1'b0, 1'b1);
    waitIdle("t3_done");
    bpMode = 0;
    checkOutput("t3_nbytes", rxBytes.size(), 32'd181);
    checkOutput("t3_hdr", rxAt(0), 32'hA5);
    checkOutput("t3_regs_last", rxAt(180), 32'h3C);

    // Requests during SEND and step_req in continuous mode are ignored.
    rxBytes.delete();
    applyStimulus(1'b0, 1'b1);
    waited = 0;
    while (rxBytes.size() < 20 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
    waitIdle("t4_done");
    repeat (5) @(negedge clk);
    checkOutput("t4_nbytes", rxBytes.size(), 32'd181);
    checkOutput("t4_still_idle", busy, 32'd0);
    mode_cont = 1'b1;
    applyStimulus(1'b1, 1'b0);
    checkOutput("t4_cont_step_ignored", busy, 32'd0);
    @(negedge clk);
    mode_cont = 1'b0;

    // Reset in the middle of a frame.
    rxBytes.delete();
    applyStimulus(1'b0, 1'b1);
    waited = 0;
    while (rxBytes.size() < 50 && waited < 300) begin
      @(negedge clk);
      #2;
      waited++;
    end
    checkOutput("t5_reach50", 32'(rxBytes.size() >= 50), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("t5_valid_drop", tx_valid, 32'd0);
    checkOutput("t5_count0", cycle_count, 32'd0);
    checkOutput("t5_busy0", busy, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rxBytes.delete();
    applyStimulus(1'b0, 1'b1);
    waitIdle("t5_done");
    checkOutput("t5_nbytes", rxBytes.size(), 32'd181);
    checkOutput("t5_hdr", rxAt(0), 32'hA5);
    checkOutput("t5_cnt_b4", rxAt(4), 32'h00);

    // Counter wrap through one step.
    @(negedge clk);
    force dut.r_cycle_count = 32'hFFFFFFFF;
    mdlCount = 32'hFFFFFFFF;
    #1;
    release dut.r_cycle_count;
    #1;
    checkOutput("t6_forced", cycle_count, 32'hFFFFFFFF);
    rxBytes.delete();
    applyStimulus(1'b1, 1'b0);
    waitIdle("t6_done");
    checkOutput("t6_nbytes", rxBytes.size(), 32'd181);
    checkOutput("t6_cnt_b1", rxAt(1), 32'h00);
    checkOutput("t6_cnt_b2", rxAt(2), 32'h00);
    checkOutput("t6_cnt_b3", rxAt(3), 32'h00);
    checkOutput("t6_cnt_b4", rxAt(4), 32'h00);
    checkOutput("t6_count_now", cycle_count, 32'd0);

    repeat (2) @(negedge clk);
    checkEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
